// File: rtl/avr_sram_system.sv
// AVR-to-SRAM bridge: serial 21-bit address loader plus a registered byte
// read/write bus FSM that owns the SRAM strobes and both data-bus turnarounds.
module avr_sram_system (
  input  logic        avr_clk,
  input  logic        avr_reset,
  input  logic        avr_si,
  input  logic        avr_sreg_en,
  input  logic        avr_oe,
  input  logic        avr_we,
  input  logic        avr_ce,
  input  logic [2:0]  avr_ctrl,
  inout  wire  [7:0]  avr_data,
  output logic [20:0] sram_addr,
  inout  wire  [7:0]  sram_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [20:0] addr_q;
  logic [7:0]  buf_q;
  logic        drv_avr, drv_sram;

  // Reserved control inputs have no function in this bridge.
  logic unused_ctrl;
  assign unused_ctrl = ^{avr_ce, avr_ctrl};

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset)         addr_q <= '0;
    else if (!avr_sreg_en) addr_q <= {addr_q[19:0], avr_si};
  end

  assign sram_addr = addr_q;

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Single buffer serves both directions; it samples whichever bus is the source.
  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) buf_q <= '0;
    else begin
      case (state_q)
        S_READ:  buf_q <= sram_data;
        S_WRITE: buf_q <= avr_data;
        default: buf_q <= buf_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (avr_sreg_en && !avr_oe)      state_d = S_READ;
        else if (avr_sreg_en && !avr_we) state_d = S_WRITE;
      end
      S_READ:  if (avr_oe || !avr_sreg_en) state_d = S_IDLE;
      S_WRITE: if (avr_we || !avr_sreg_en) state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and bus enables depend on state alone, so reset releases them at once.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    drv_avr   = 1'b0;
    drv_sram  = 1'b0;
    case (state_q)
      S_READ: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        drv_avr   = 1'b1;
      end
      S_WRITE: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        drv_sram  = 1'b1;
      end
      S_HOLD: begin
        sram_ce_n = 1'b0;
        drv_sram  = 1'b1;
      end
      default: ;
    endcase
  end

  assign avr_data  = drv_avr  ? buf_q : 8'hzz;
  assign sram_data = drv_sram ? buf_q : 8'hzz;

endmodule

// File: tb/tb_avr_sram_system.sv
// Randomized and directed bench for avr_sram_system against a cycle-level
// behavioural model; undriven bus lines are pulled up and read as 0xFF.
module tb_avr_sram_system;

  logic        avr_clk = 1'b0;
  logic        avr_reset, avr_si, avr_sreg_en, avr_oe, avr_we, avr_ce;
  logic [2:0]  avr_ctrl;
  logic [20:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  tri1  [7:0]  avr_data;
  tri1  [7:0]  sram_data;

  // Bus-partner drivers: "want" is the stimulus, "drv_en" keeps clear of the DUT.
  logic       avr_want, sram_want, avr_drv_en, sram_drv_en;
  logic [7:0] avr_val, sram_val;

  assign avr_data  = avr_drv_en  ? avr_val  : 8'hzz;
  assign sram_data = sram_drv_en ? sram_val : 8'hzz;

  avr_sram_system dut (
    .avr_clk(avr_clk), .avr_reset(avr_reset), .avr_si(avr_si),
    .avr_sreg_en(avr_sreg_en), .avr_oe(avr_oe), .avr_we(avr_we),
    .avr_ce(avr_ce), .avr_ctrl(avr_ctrl), .avr_data(avr_data),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 avr_clk = ~avr_clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model: bus mode, data byte, address value.
  localparam int M_IDLE = 0, M_RD = 1, M_WR = 2, M_HOLD = 3;
  int         m_mode;
  logic [7:0] m_buf;
  int         m_addr;

  function automatic int mode_after(int mode, logic en, logic oe_n, logic we_n);
    if (mode == M_IDLE) return (en && !oe_n) ? M_RD : ((en && !we_n) ? M_WR : M_IDLE);
    if (mode == M_RD)   return (oe_n || !en) ? M_IDLE : M_RD;
    if (mode == M_WR)   return (we_n || !en) ? M_HOLD : M_WR;
    return M_IDLE;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_buf  = 8'h00;
    m_addr = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] strobes;
    logic [7:0] exp_avr, exp_sram;
    case (m_mode)
      M_RD:    strobes = 3'b001;
      M_WR:    strobes = 3'b010;
      M_HOLD:  strobes = 3'b011;
      default: strobes = 3'b111;
    endcase
    exp_avr  = (m_mode == M_RD) ? m_buf : (avr_drv_en ? avr_val : 8'hFF);
    exp_sram = (m_mode == M_WR || m_mode == M_HOLD) ? m_buf : (sram_drv_en ? sram_val : 8'hFF);
    chk({tag, ".addr"},    sram_addr, m_addr);
    chk({tag, ".strobes"}, {sram_ce_n, sram_oe_n, sram_we_n}, strobes);
    chk({tag, ".avr_data"},  avr_data,  exp_avr);
    chk({tag, ".sram_data"}, sram_data, exp_sram);
  endtask

  // One clock: inputs are already set; predict, step, compare.
  task automatic cycle(input string tag);
    int         nxt;
    logic [7:0] seen_avr, seen_sram;
    nxt = mode_after(m_mode, avr_sreg_en, avr_oe, avr_we);
    avr_drv_en  = avr_want  && m_mode != M_RD && nxt != M_RD;
    sram_drv_en = sram_want && !(m_mode inside {M_WR, M_HOLD}) && !(nxt inside {M_WR, M_HOLD});
    seen_avr  = avr_drv_en  ? avr_val  : 8'hFF;
    seen_sram = sram_drv_en ? sram_val : 8'hFF;
    @(posedge avr_clk);
    #1;
    if (m_mode == M_RD)      m_buf = seen_sram;
    else if (m_mode == M_WR) m_buf = seen_avr;
    if (!avr_sreg_en) m_addr = ((m_addr << 1) | int'(avr_si)) & 32'h1F_FFFF;
    m_mode = nxt;
    check_outputs(tag);
  endtask

  initial begin
    logic [15:0] pat;
    avr_reset = 1'b1; avr_si = 1'b0; avr_sreg_en = 1'b0;
    avr_oe = 1'b1; avr_we = 1'b1; avr_ce = 1'b1; avr_ctrl = 3'b000;
    avr_want = 1'b0; sram_want = 1'b0; avr_drv_en = 1'b0; sram_drv_en = 1'b0;
    avr_val = 8'h00; sram_val = 8'h00;
    model_reset();
    repeat (2) @(posedge avr_clk);
    #1;
    check_outputs("reset");
    avr_reset = 1'b0;

    // Address load, first bit ends up most significant.
    pat = 16'hCCCF;
    for (int i = 15; i >= 0; i--) begin
      avr_si = pat[i];
      cycle("shift");
    end
    chk("addr_load", sram_addr, 21'h00CCCF);
    avr_sreg_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      avr_si = 1'($urandom_range(0, 1));
      cycle("frozen");
    end
    chk("addr_frozen", sram_addr, 21'h00CCCF);

    // Read of 0xAA.
    sram_want = 1'b1; sram_val = 8'hAA; avr_oe = 1'b0;
    cycle("rd1");
    chk("rd_strobe", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b001);
    cycle("rd2");
    chk("rd_data", avr_data, 8'hAA);
    cycle("rd3");
    avr_oe = 1'b1;
    cycle("rd_end");
    chk("rd_release", {sram_ce_n, sram_oe_n, sram_we_n, avr_data}, {3'b111, 8'hFF});

    // Back-to-back read of 0xBB.
    sram_val = 8'hBB;
    cycle("b2b_gap");
    avr_oe = 1'b0;
    cycle("b2b1");
    cycle("b2b2");
    chk("b2b_data", avr_data, 8'hBB);

    // Write of 0xEE with data hold.
    avr_oe = 1'b1; sram_want = 1'b0;
    cycle("wr_gap");
    avr_we = 1'b0; avr_want = 1'b1; avr_val = 8'hEE;
    cycle("wr1");
    chk("wr_strobe", {sram_oe_n, sram_we_n}, 2'b10);
    cycle("wr2");
    chk("wr_data", sram_data, 8'hEE);
    avr_we = 1'b1;
    cycle("wr_hold");
    chk("wr_hold", {sram_ce_n, sram_we_n, sram_data}, {2'b01, 8'hEE});
    avr_want = 1'b0;
    cycle("wr_end");
    chk("turnaround", {avr_data, sram_data}, 16'hFFFF);

    // Turnaround into a read of 0x22.
    avr_oe = 1'b0; sram_want = 1'b1; sram_val = 8'h22;
    cycle("ta1");
    cycle("ta2");
    chk("ta_data", avr_data, 8'h22);

    // Read wins over write; asynchronous reset mid-read.
    avr_oe = 1'b1;
    cycle("pri_gap");
    avr_oe = 1'b0; avr_we = 1'b0;
    cycle("pri");
    chk("priority", {sram_oe_n, sram_we_n}, 2'b01);
    #3 avr_reset = 1'b1;
    #1;
    chk("async_rst", {sram_ce_n, sram_oe_n, sram_we_n, avr_data, sram_addr},
        {3'b111, 8'hFF, 21'h0});
    model_reset();
    @(posedge avr_clk);
    #1 avr_reset = 1'b0;
    avr_oe = 1'b1; avr_we = 1'b1;

    // Random traffic: long-ish transactions, occasional address shifting.
    for (int i = 0; i < 400; i++) begin
      avr_si      = 1'($urandom_range(0, 1));
      avr_ce      = 1'($urandom_range(0, 1));
      avr_ctrl    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) avr_sreg_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) avr_oe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) avr_we = 1'($urandom_range(0, 1));
      avr_want  = ($urandom_range(0, 4) != 0);
      sram_want = ($urandom_range(0, 4) != 0);
      avr_val   = 8'($urandom_range(0, 254));
      sram_val  = 8'($urandom_range(0, 254));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
